tr_stepper_reg: RTL and testbench

- Parametrised closed-loop stepper regulator, successor to the single-channel TR tracking block.
- Compares each valid ADC sample x against setpoint x0 and classifies the signed error into one of three zones: hold, slow or fast.
- Drives a step/dir stepper driver with a programmable direction setup time, step pulse width and per-zone step period.
- Adds a signed position counter that tracks issued steps.

---
 rtl/tr_stepper_reg.sv | 187 ++++++++++++++++++
 tb/tb_tr_stepper_reg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tr_stepper_reg.sv
// Closed-loop stepper regulator: classifies ADC error into hold/slow/fast zones
// and drives a step/dir driver with setup time, pulse width and per-zone period.
module tr_stepper_reg #(
    parameter int W         = 12,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 25,
    parameter int DIV_SLOW  = 1000,
    parameter int DIV_FAST  = 100,
    parameter int POS_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     x,
    input  logic             data_valid,
    input  logic [W-1:0]     x0,
    input  logic [W-1:0]     dx1,
    input  logic [W-1:0]     dx2,
    input  logic             enable,
    output logic             drv_SM,
    output logic             drv_step,
    output logic             drv_dir,
    output logic [1:0]       zone,
    output logic [POS_W-1:0] pos_cnt,
    output logic             busy
);

    if (!(PULSE_W >= 1 && PULSE_W < DIV_FAST && DIV_FAST <= DIV_SLOW)) begin : g_param_check
        $error("tr_stepper_reg: parameters must satisfy 1 <= PULSE_W < DIV_FAST <= DIV_SLOW");
    end

    localparam int CNT_MAX = (DIV_SLOW > DIR_SETUP) ? DIV_SLOW : DIR_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIRSET  = 2'd1,
        S_STEP_HI = 2'd2,
        S_STEP_LO = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         zone_reg, zone_next;
    logic               dir_req_reg, dir_req_next;
    logic               drv_sm_reg, drv_sm_next;
    logic               drv_step_reg, drv_step_next;
    logic               drv_dir_reg, drv_dir_next;
    logic [POS_W-1:0]   pos_cnt_reg, pos_cnt_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   period_reg, period_next;

    logic               start_dir;
    logic               start_step;
    logic               end_pulse;
    logic               zone_active;
    logic [W-1:0]       abs_err;
    logic [1:0]         zone_calc;

    // |x - x0| taken from whichever ordering is non-negative, so it always fits W bits.
    always_comb begin
        abs_err   = (x >= x0) ? (x - x0) : (x0 - x);
        zone_calc = 2'd1;
        if (abs_err <= dx1) begin
            zone_calc = 2'd0;
        end else if (abs_err > dx2) begin
            zone_calc = 2'd2;
        end
    end

    assign zone_active = (zone_reg != 2'd0) && enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            zone_reg     <= 2'd0;
            dir_req_reg  <= 1'b0;
            drv_sm_reg   <= 1'b0;
            drv_step_reg <= 1'b0;
            drv_dir_reg  <= 1'b0;
            pos_cnt_reg  <= '0;
            cnt_reg      <= '0;
            period_reg   <= CNT_W'(DIV_SLOW);
        end else begin
            state_reg    <= state_next;
            zone_reg     <= zone_next;
            dir_req_reg  <= dir_req_next;
            drv_sm_reg   <= drv_sm_next;
            drv_step_reg <= drv_step_next;
            drv_dir_reg  <= drv_dir_next;
            pos_cnt_reg  <= pos_cnt_next;
            cnt_reg      <= cnt_next;
            period_reg   <= period_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_dir  = 1'b0;
        start_step = 1'b0;
        end_pulse  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (zone_active) begin
                    if (dir_req_reg != drv_dir_reg) begin
                        start_dir  = 1'b1;
                        state_next = S_DIRSET;
                    end else begin
                        start_step = 1'b1;
                        state_next = S_STEP_HI;
                    end
                end
            end
            S_DIRSET: begin
                // A demand that reversed again during setup goes back through IDLE.
                if (cnt_reg == CNT_W'(DIR_SETUP)) begin
                    if (zone_active && (dir_req_reg == drv_dir_reg)) begin
                        start_step = 1'b1;
                        state_next = S_STEP_HI;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_STEP_HI: begin
                if (cnt_reg == CNT_W'(PULSE_W - 1)) begin
                    end_pulse  = 1'b1;
                    state_next = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                if (cnt_reg == period_reg - CNT_W'(1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        zone_next     = zone_reg;
        dir_req_next  = dir_req_reg;
        drv_sm_next   = drv_sm_reg;
        drv_step_next = drv_step_reg;
        drv_dir_next  = drv_dir_reg;
        pos_cnt_next  = pos_cnt_reg;
        cnt_next      = cnt_reg;
        period_next   = period_reg;

        if (!enable) begin
            zone_next = 2'd0;
        end else if (data_valid) begin
            zone_next    = zone_calc;
            dir_req_next = (x > x0);
        end

        if (enable) begin
            drv_sm_next = 1'b1;
        end else if (state_next == S_IDLE) begin
            drv_sm_next = 1'b0;
        end

        if (start_dir || start_step) begin
            cnt_next = '0;
        end else if (state_reg != S_IDLE) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        if (start_dir) begin
            drv_dir_next = dir_req_reg;
        end

        if (start_step) begin
            drv_step_next = 1'b1;
            period_next   = (zone_reg == 2'd2) ? CNT_W'(DIV_FAST) : CNT_W'(DIV_SLOW);
            pos_cnt_next  = drv_dir_reg ? (pos_cnt_reg + POS_W'(1)) : (pos_cnt_reg - POS_W'(1));
        end else if (end_pulse) begin
            drv_step_next = 1'b0;
        end
    end

    assign drv_SM   = drv_sm_reg;
    assign drv_step = drv_step_reg;
    assign drv_dir  = drv_dir_reg;
    assign zone     = zone_reg;
    assign pos_cnt  = pos_cnt_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_tr_stepper_reg.sv
// Directed bench for tr_stepper_reg: zones, latencies, step timing, enable/reset
// behaviour, plus a narrow-counter instance for position wrap-around.
module tb_tr_stepper_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x, x0, dx1, dx2;
    logic        data_valid, enable;
    logic        drv_SM, drv_step, drv_dir, busy;
    logic [1:0]  zone;
    logic [15:0] pos_cnt;

    logic [11:0] w_x, w_x0, w_dx1, w_dx2;
    logic        w_dv, w_en;
    logic        w_sm, w_step, w_dir, w_busy;
    logic [1:0]  w_zone;
    logic [3:0]  w_pos;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    tr_stepper_reg dut (
        .clk(clk), .rst(rst), .x(x), .data_valid(data_valid), .x0(x0),
        .dx1(dx1), .dx2(dx2), .enable(enable), .drv_SM(drv_SM),
        .drv_step(drv_step), .drv_dir(drv_dir), .zone(zone),
        .pos_cnt(pos_cnt), .busy(busy)
    );

    tr_stepper_reg #(
        .W(12), .PULSE_W(2), .DIR_SETUP(1), .DIV_SLOW(8), .DIV_FAST(4), .POS_W(4)
    ) dut_wrap (
        .clk(clk), .rst(rst), .x(w_x), .data_valid(w_dv), .x0(w_x0),
        .dx1(w_dx1), .dx2(w_dx2), .enable(w_en), .drv_SM(w_sm),
        .drv_step(w_step), .drv_dir(w_dir), .zone(w_zone),
        .pos_cnt(w_pos), .busy(w_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: expected position from seen edges, pulse widths, direction toggles.
    logic        mon_step = 1'b0;
    logic        mon_dir  = 1'b0;
    logic [15:0] exp_pos  = 16'd0;
    int          run_len  = 0;
    int          min_w    = 100000;
    int          max_w    = 0;
    int          dir_toggles = 0;

    always @(posedge clk) begin
        mon_step <= drv_step;
        mon_dir  <= drv_dir;
        if (rst) begin
            exp_pos <= 16'd0;
        end else if (drv_step && !mon_step) begin
            exp_pos <= drv_dir ? exp_pos + 16'd1 : exp_pos - 16'd1;
        end
        if (drv_dir != mon_dir) dir_toggles <= dir_toggles + 1;
        if (drv_step) begin
            run_len <= run_len + 1;
        end else if (run_len > 0) begin
            if (run_len < min_w) min_w <= run_len;
            if (run_len > max_w) max_w <= run_len;
            run_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) begin
            $display("chk %-20s observed=%0d expected=%0d ok", tag, obs, exp_v);
        end else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int xv, output int t);
        x = 12'(xv);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_rise(input int limit, output int at, output bit ok);
        logic prev;
        prev = drv_step;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (drv_step && !prev) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            prev = drv_step;
        end
    endtask

    task automatic wait_fall(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!drv_step) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_dir(input logic val, input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (drv_dir == val) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int zmodel(input int xv, input int x0v, input int d1, input int d2);
        int a;
        a = (xv >= x0v) ? xv - x0v : x0v - xv;
        if (a <= d1) return 0;
        if (a > d2) return 2;
        return 1;
    endfunction

    initial begin
        int t, r1, r2, f1, d, tog0, steps_seen, smf;
        bit ok;
        logic prev_w;
        logic [3:0] e4;

        // 1. reset and hold
        rst = 1'b1; enable = 1'b1; data_valid = 1'b0;
        x = 12'd100; x0 = 12'd100; dx1 = 12'd10; dx2 = 12'd100;
        w_x = 12'd10; w_x0 = 12'd10; w_dx1 = 12'd1; w_dx2 = 12'd2;
        w_dv = 1'b0; w_en = 1'b1;
        tick(5);
        chk("rst_zone", 32'(zone), 0);
        chk("rst_step", 32'(drv_step), 0);
        chk("rst_dir", 32'(drv_dir), 0);
        chk("rst_pos", 32'($signed(pos_cnt)), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sm", 32'(drv_SM), 0);
        rst = 1'b0;
        tick(1);
        chk("sm_after_enable", 32'(drv_SM), 1);
        steps_seen = 0;
        for (int i = 0; i < 30; i++) begin
            data_valid = (i % 5 == 0);
            tick(1);
            if (drv_step) steps_seen++;
        end
        data_valid = 1'b0;
        chk("hold_steps", steps_seen, 0);
        chk("hold_zone", 32'(zone), 0);
        chk("hold_pos", 32'($signed(pos_cnt)), 0);

        // 2. slow zone, reaching drv_dir=1 through a direction setup
        strobe(150, t);
        chk("slow_zone", 32'(zone), 1);
        tick(1);
        chk("slow_dir_t2", 32'(drv_dir), 1);
        wait_rise(100, r1, ok);
        chk("slow_rise_seen", 32'(ok), 1);
        chk("dirchg_latency", r1 - t, 27);
        chk("slow_pos1", 32'($signed(pos_cnt)), 1);
        wait_fall(100, f1, ok);
        chk("slow_width", f1 - r1, 50);
        wait_rise(1100, r2, ok);
        chk("slow_interval", r2 - r1, 1001);
        chk("slow_pos2", 32'($signed(pos_cnt)), 2);

        // 3. fast zone from idle, then reversal
        strobe(100, t);
        tick(1100);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_zone", 32'(zone), 0);
        dx2 = 12'd99;
        strobe(300, t);
        chk("fast_zone", 32'(zone), 2);
        wait_rise(10, r1, ok);
        chk("fast_latency", r1 - t, 1);
        chk("fast_pos3", 32'($signed(pos_cnt)), 3);
        wait_rise(200, r2, ok);
        chk("fast_interval", r2 - r1, 101);
        chk("fast_pos4", 32'($signed(pos_cnt)), 4);
        strobe(0, t);
        chk("rev_zone", 32'(zone), 2);
        wait_dir(1'b0, 200, d, ok);
        chk("rev_dir_fall", d - r2, 101);
        wait_rise(100, r1, ok);
        chk("rev_setup", r1 - d, 26);
        chk("rev_pos3", 32'($signed(pos_cnt)), 3);
        wait_rise(200, r2, ok);
        chk("rev_interval", r2 - r1, 101);
        chk("rev_pos2", 32'($signed(pos_cnt)), 2);

        // 4. ramp 125 -> 75 through both thresholds
        dx1 = 12'd10; dx2 = 12'd20;
        tog0 = dir_toggles;
        for (int xv = 125; xv >= 75; xv--) begin
            strobe(xv, t);
            chk($sformatf("ramp_zone_x%0d", xv), 32'(zone), zmodel(xv, 100, 10, 20));
            tick(38);
        end
        tick(1200);
        chk("ramp_dir_final", 32'(drv_dir), 0);
        chk("ramp_dir_toggles", dir_toggles - tog0, 2);
        chk("min_pulse_width", min_w, 50);
        chk("max_pulse_width", max_w, 50);
        chk("ramp_pos_track", 32'($signed(pos_cnt)), 32'($signed(exp_pos)));

        // 5. enable dropped during STEP_HI
        wait_rise(200, r1, ok);
        chk("dis_rise_seen", 32'(ok), 1);
        tick(10);
        enable = 1'b0;
        tick(1);
        chk("dis_zone", 32'(zone), 0);
        chk("dis_sm_still", 32'(drv_SM), 1);
        wait_fall(100, f1, ok);
        chk("dis_width", f1 - r1, 50);
        smf = -1;
        for (int i = 0; i < 200; i++) begin
            if (!drv_SM) begin
                smf = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("dis_sm_fall", smf - r1, 100);
        chk("dis_busy", 32'(busy), 0);
        wait_rise(300, r2, ok);
        chk("dis_no_step", 32'(ok), 0);
        chk("dis_pos_track", 32'($signed(pos_cnt)), 32'($signed(exp_pos)));

        // 6. reset mid-pulse
        enable = 1'b1;
        tick(2);
        chk("reen_sm", 32'(drv_SM), 1);
        strobe(200, t);
        wait_rise(100, r1, ok);
        chk("pre_rst_rise", 32'(ok), 1);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midrst_step", 32'(drv_step), 0);
        chk("midrst_pos", 32'($signed(pos_cnt)), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_dir", 32'(drv_dir), 0);
        chk("midrst_zone", 32'(zone), 0);
        rst = 1'b0;

        // Wrap-around on the 4-bit instance: +7 then one more step reads -8
        w_x = 12'd50;
        w_dv = 1'b1;
        tick(1);
        w_dv = 1'b0;
        prev_w = w_step;
        for (int k = 1; k <= 8; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (w_step && !prev_w) begin
                    ok = 1'b1;
                    prev_w = w_step;
                    break;
                end
                prev_w = w_step;
            end
            e4 = 4'(k);
            chk($sformatf("wrap_rise_%0d", k), 32'(ok), 1);
            chk($sformatf("wrap_pos_%0d", k), 32'($signed(w_pos)), 32'($signed(e4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
